io_slot_bridge: RTL
===================

# io_slot_bridge

Parametrised memory-mapped I/O bus slave for the PSX I/O region. It decodes CPU `ren`/`wen` requests within a configurable address window into `NUM_SLOTS` equal-sized peripheral slots and forwards each access to the selected peripheral over a level-held request/ack handshake. It returns read data and `ack` to the CPU, and enforces a per-access timeout. It sits between the memory controller and the timer, interrupt, DMA, GPU and peripheral register blocks.

## Interface
- `BASE_ADDR`, 32'h1F80_1000, window base; must be aligned to 2^`SLOT_BITS`.
- `SLOT_BITS`, 4, log2 of slot size in bytes (16-byte slots).
- `NUM_SLOTS`, 16, number of peripheral slots (≥1).
- `TIMEOUT`, 15, maximum BUSY cycles before abort (≥1).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `addr`  in  32  CPU byte address.
- `data_i`  in  32  CPU write data.
- `wen`, `ren`  in  1 each  CPU write/read request, level-held until `ack` is seen.
- `ben`  in  4  CPU byte enables.
- `ack`  out  1  one-cycle response strobe.
- `data_o`  out  32  registered read data.
- `err`  out  1  one-cycle pulse coincident with `ack` on decode miss or timeout.
- `err_cnt`  out  8  saturating count of `err` pulses.
- `dev_sel`  out  NUM_SLOTS  one-hot slot select.
- `dev_addr`  out  SLOT_BITS  byte offset within the slot.
- `dev_wdata`  out  32  captured write data.
- `dev_ben`  out  4  captured byte enables.
- `dev_wen`, `dev_ren`  out  1 each  device strobes.
- `dev_ack`  in  NUM_SLOTS  per-slot completion.
- `dev_rdata`  in  NUM_SLOTS*32  per-slot read data; slot i occupies bits [32i+31:32i].

## Operation
- **States:** IDLE, BUSY, RESP, HOLD. One-hot or binary encoding is an implementation choice.
- **IDLE:** samples `ren`/`wen`. `ren` has priority when both are high.
  - On a request: captures `addr`, `data_i`, `ben` and the op into internal registers. All device outputs are driven from these captured values, never from live CPU inputs.
- **Decode:**
  - In-window iff `BASE_ADDR ≤ addr < BASE_ADDR + (NUM_SLOTS << SLOT_BITS)`. Compare at 33 bits so the upper bound cannot wrap.
  - slot = (addr − BASE_ADDR) >> SLOT_BITS.
  - `dev_addr` = addr[SLOT_BITS-1:0].
- **IDLE transitions:**
  - Out-of-window request: go to RESP with err flagged.
  - Write with `ben`==0: go to RESP, no device access, no err.
  - Otherwise: go to BUSY and clear the timeout counter.
- **BUSY:**
  - `dev_sel`[slot] and `dev_ren` or `dev_wen` are held high every cycle.
  - If `dev_ack`[slot]==1: go to RESP. On a read, capture `dev_rdata`[slot] into the response data.
  - Otherwise, if counter == TIMEOUT−1: go to RESP with err and response data 0. Otherwise increment the counter.
  - An ack arriving on the final count wins over the timeout.
  - `dev_ack` bits of non-selected slots are ignored.
- **RESP:** `ack`=1 for exactly one cycle. `err`=1 if flagged. `err_cnt` increments on `err`, saturating at 255. Then go to HOLD.
- **`data_o` update on entry to RESP:**
  - read ack: device data.
  - read error or timeout: 0.
  - writes: `data_o` unchanged.
  - `data_o` holds its value until the next read response.
- **HOLD:** waits until `ren`==0 and `wen`==0, then goes to IDLE. A request cannot be re-issued without deasserting first.
- **Device outputs outside BUSY:** `dev_sel`, `dev_ren`, `dev_wen` are 0. `dev_addr`, `dev_wdata`, `dev_ben` hold their last captured values.

## Timing
- **Reset:** a synchronous `rst` in any state puts the block in IDLE at the next edge.
  - `ack`, `err`, `data_o`, `err_cnt`, `dev_sel`, `dev_ren`, `dev_wen`, `dev_addr`, `dev_wdata`, `dev_ben` are all 0 after that edge.
  - An in-flight access is dropped with no `ack`.
- **Cycle numbering:** the request is sampled at edge 0. BUSY is visible in cycle 1, with device strobes high from cycle 1.
- **Device acks in BUSY cycle n (n≥1):** `ack` is high in cycle n+1. Minimum CPU latency is 2 cycles.
- **Decode miss or `ben`==0 write:** `ack` is high in cycle 1.
- **Timeout without ack:** BUSY spans cycles 1..TIMEOUT. `ack` and `err` are high in cycle TIMEOUT+1.
- **`data_o` validity:** valid in the same cycle `ack` is high, and stable afterwards.
- **Request held through `ack`:** the block stays in HOLD with no second access. IDLE is re-entered the cycle after both requests drop.

## Test plan
- **Read hit:** `ren` at 0x1F80_1074, slot 7 acks in first BUSY cycle with 0x0000_0401 -> `dev_sel`=0x0080, `dev_addr`=4, `ack` in cycle 2, `data_o`=0x0000_0401, `err`=0.
- **Write with wait states:** `wen` at 0x1F80_1104, `ben`=4'b0011, data 0x1234; slot 0x10 of a NUM_SLOTS=32 build acks after 5 cycles.
  - Required: `dev_wen` held cycles 1–5, `dev_wdata`=0x1234, `dev_ben`=4'b0011, `ack` in cycle 6.
  - Required: `data_o` unchanged.
- **Timeout:** TIMEOUT=15, read slot 3, no `dev_ack` -> `ack`+`err` in cycle 16, `data_o`=0, `err_cnt`=1. An ack on cycle 15 instead yields a normal response.
- **Decode miss:** `ren` at 0x1F80_0FFC, then at 0x1F80_1100 with NUM_SLOTS=16 -> both give `ack`+`err` in cycle 1 and no `dev_sel` activity. `err_cnt` is 2.
- **Priority and hold:**
  - `ren` and `wen` asserted together: a read is performed.
  - Requests held 4 cycles past `ack`: no second `dev_sel`. IDLE follows the drop.
  - Stray ack: `dev_ack` on a non-selected slot is ignored.
- **Reset mid-access:** `rst` in BUSY cycle 3 -> all outputs 0 next cycle, no `ack`. A fresh read afterwards completes normally. 256 forced errors leave `err_cnt`=255.

Source files
------------

// File: rtl/io_slot_bridge.sv
// Memory-mapped I/O slave: decodes CPU accesses into equal-sized peripheral slots and
// forwards them over a level-held request/ack handshake with a per-access timeout.
module io_slot_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h1F80_1000,
  parameter int          SLOT_BITS = 4,
  parameter int          NUM_SLOTS = 16,
  parameter int          TIMEOUT   = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               addr,
  input  logic [31:0]               data_i,
  input  logic                      wen,
  input  logic                      ren,
  input  logic [3:0]                ben,
  output logic                      ack,
  output logic [31:0]               data_o,
  output logic                      err,
  output logic [7:0]                err_cnt,
  output logic [NUM_SLOTS-1:0]      dev_sel,
  output logic [SLOT_BITS-1:0]      dev_addr,
  output logic [31:0]               dev_wdata,
  output logic [3:0]                dev_ben,
  output logic                      dev_wen,
  output logic                      dev_ren,
  input  logic [NUM_SLOTS-1:0]      dev_ack,
  input  logic [NUM_SLOTS*32-1:0]   dev_rdata
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Window bounds carried at 33 bits so the upper limit cannot wrap past 2^32.
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'(NUM_SLOTS) << SLOT_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP,
    S_HOLD
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t                state_q, state_d;
  logic                  op_rd_q, op_rd_d;
  logic [SLOT_BITS-1:0]  addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            ben_q, ben_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic                  err_flag_q, err_flag_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           data_q, data_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic [32:0]           addr_x;
  logic [32:0]           offset;
  logic                  in_win;
  logic [SLOT_W-1:0]     slot_n;
  logic [NUM_SLOTS-1:0]  sel_oh;
  logic [31:0]           rd_mux;
  logic                  ack_hit;
  logic                  busy;

  assign addr_x = {1'b0, addr};
  assign offset = addr_x - WIN_LO;
  assign in_win = (addr_x >= WIN_LO) && (addr_x < WIN_HI);
  assign slot_n = SLOT_W'(offset >> SLOT_BITS);

  always_comb begin
    sel_oh = '0;
    rd_mux = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        sel_oh[i] = 1'b1;
        rd_mux    = dev_rdata[32*i +: 32];
      end
    end
  end

  // Acks from slots other than the captured one are masked off here.
  assign ack_hit = |(dev_ack & sel_oh);
  assign busy    = (state_q == S_BUSY);

  always_comb begin
    state_d    = state_q;
    op_rd_d    = op_rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ben_d      = ben_q;
    slot_d     = slot_q;
    err_flag_d = err_flag_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ren || wen) begin
          op_rd_d    = ren;
          addr_d     = addr[SLOT_BITS-1:0];
          wdata_d    = data_i;
          ben_d      = ben;
          slot_d     = slot_n;
          err_flag_d = 1'b0;
          cnt_d      = '0;
          if (!in_win) begin
            state_d    = S_RESP;
            err_flag_d = 1'b1;
            if (ren) data_d = '0;
          end else if (!ren && (ben == 4'b0000)) begin
            state_d = S_RESP;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (ack_hit) begin
          state_d = S_RESP;
          if (op_rd_q) data_d = rd_mux;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d    = S_RESP;
          err_flag_d = 1'b1;
          if (op_rd_q) data_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_HOLD;
        if (err_flag_q) err_cnt_d = sat_inc8(err_cnt_q);
      end
      S_HOLD: begin
        if (!ren && !wen) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_rd_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ben_q      <= '0;
      slot_q     <= '0;
      err_flag_q <= 1'b0;
      cnt_q      <= '0;
      data_q     <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_rd_q    <= op_rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ben_q      <= ben_d;
      slot_q     <= slot_d;
      err_flag_q <= err_flag_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign ack       = (state_q == S_RESP);
  assign err       = ack && err_flag_q;
  assign err_cnt   = err_cnt_q;
  assign data_o    = data_q;
  assign dev_sel   = busy ? sel_oh : '0;
  assign dev_ren   = busy && op_rd_q;
  assign dev_wen   = busy && !op_rd_q;
  assign dev_addr  = addr_q;
  assign dev_wdata = wdata_q;
  assign dev_ben   = ben_q;

endmodule
